// File: rtl/chess_time_core.sv
// -----------------------------------------------------------------------------
// chess_time_core
// Two-player chess-clock timekeeping core. Each player's remaining time is held
// as four BCD digits (M10 M1 : S10 S1). The running player counts down once per
// CE tick. Also handles move-end buttons with Fischer increment, pause, flag
// fall and new game. All eight digits leave as registered 7-segment patterns.
//
// Parameters
//   START_MIN  initial minutes per player (1..99), seconds start at 00
//   INC_SEC    Fischer increment in seconds (0..59)
// Ports
//   CLK, CLR_N              clock, asynchronous active-low reset
//   CE                      1 Hz tick, one CLK cycle wide
//   START, PAUSE, NEW_GAME  one-cycle control pulses
//   BTN_P1, BTN_P2          one-cycle end-of-move pulses
//   seg1..seg4              player 1 M10, M1, S10, S1 (bit0 = a .. bit6 = g)
//   seg5..seg8              player 2 M10, M1, S10, S1
//   run_p1, run_p2          named player's clock is counting
//   paused                  clock is paused
//   flag_p1, flag_p2        named player's time ran out
// -----------------------------------------------------------------------------
module chess_time_core #(
   parameter int START_MIN = 5,
   parameter int INC_SEC   = 0
) (
   input  logic       CLK,
   input  logic       CLR_N,
   input  logic       CE,
   input  logic       START,
   input  logic       PAUSE,
   input  logic       NEW_GAME,
   input  logic       BTN_P1,
   input  logic       BTN_P2,
   output logic [6:0] seg1,
   output logic [6:0] seg2,
   output logic [6:0] seg3,
   output logic [6:0] seg4,
   output logic [6:0] seg5,
   output logic [6:0] seg6,
   output logic [6:0] seg7,
   output logic [6:0] seg8,
   output logic       run_p1,
   output logic       run_p2,
   output logic       paused,
   output logic       flag_p1,
   output logic       flag_p2
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RUN_P1 = 3'd1,
      S_RUN_P2 = 3'd2,
      S_PAUSED = 3'd3,
      S_FLAG   = 3'd4
   } state_t;

   localparam logic [3:0]  START_M10 = 4'(START_MIN / 10);
   localparam logic [3:0]  START_M1  = 4'(START_MIN % 10);
   localparam logic [15:0] T_START   = {START_M10, START_M1, 8'h00};
   localparam logic [6:0]  INC_7     = 7'(INC_SEC);

   // BCD mm:ss minus one second; 00:00 stays at 00:00.
   function automatic logic [15:0] bcd_dec(input logic [15:0] t);
      logic [3:0] m10, m1, s10, s1;
      {m10, m1, s10, s1} = t;
      if (t == 16'h0000) begin
         s1 = 4'd0;
      end else if (s1 != 4'd0) begin
         s1 = s1 - 4'd1;
      end else if (s10 != 4'd0) begin
         s1  = 4'd9;
         s10 = s10 - 4'd1;
      end else begin
         // ss = 00 with a non-zero time, so minutes are non-zero here
         s1  = 4'd9;
         s10 = 4'd5;
         if (m1 != 4'd0) begin
            m1 = m1 - 4'd1;
         end else begin
            m1  = 4'd9;
            m10 = m10 - 4'd1;
         end
      end
      return {m10, m1, s10, s1};
   endfunction

   // BCD mm:ss plus INC_SEC seconds, saturating at 99:59. Done in binary
   // because the operands are tiny (seconds <= 118, minutes <= 100).
   function automatic logic [15:0] bcd_inc(input logic [15:0] t);
      logic [6:0]  sec_v;
      logic [6:0]  min_v;
      logic [15:0] res;
      sec_v = {3'b000, t[7:4]} * 7'd10 + {3'b000, t[3:0]} + INC_7;
      min_v = {3'b000, t[15:12]} * 7'd10 + {3'b000, t[11:8]};
      if (sec_v >= 7'd60) begin
         sec_v = sec_v - 7'd60;
         min_v = min_v + 7'd1;
      end else begin
         sec_v = sec_v;
      end
      if (min_v > 7'd99) begin
         res = 16'h9959;
      end else begin
         res = {4'(min_v / 7'd10), 4'(min_v % 7'd10),
                4'(sec_v / 7'd10), 4'(sec_v % 7'd10)};
      end
      return res;
   endfunction

   // BCD digit to active-high a..g pattern; non-BCD values are blank.
   function automatic logic [6:0] seg_enc(input logic [3:0] d);
      logic [6:0] p;
      case (d)
         4'd0:    p = 7'h3F;
         4'd1:    p = 7'h06;
         4'd2:    p = 7'h5B;
         4'd3:    p = 7'h4F;
         4'd4:    p = 7'h66;
         4'd5:    p = 7'h6D;
         4'd6:    p = 7'h7D;
         4'd7:    p = 7'h07;
         4'd8:    p = 7'h7F;
         4'd9:    p = 7'h6F;
         default: p = 7'h00;
      endcase
      return p;
   endfunction

   state_t      state_q, state_d;
   logic        last_q, last_d;     // 0: player 1 was running, 1: player 2
   logic [15:0] t1_q, t1_d;
   logic [15:0] t2_q, t2_d;

   logic [15:0] t_act_s;
   logic [15:0] t_dec_s;
   logic [15:0] t_inc_s;
   logic [15:0] t_new_s;
   logic        btn_act_s;
   logic        flag_hit_s;

   // Datapath for the running player: tick decrement, then increment on top.
   always_comb begin
      if (state_q == S_RUN_P2) begin
         t_act_s   = t2_q;
         btn_act_s = BTN_P2 & ~BTN_P1;
      end else begin
         t_act_s   = t1_q;
         btn_act_s = BTN_P1 & ~BTN_P2;
      end
      if (CE) begin
         t_dec_s = bcd_dec(t_act_s);
      end else begin
         t_dec_s = t_act_s;
      end
      t_inc_s    = bcd_inc(t_dec_s);
      flag_hit_s = CE & (t_dec_s == 16'h0000);
   end

   // Next-state logic; priority: NEW_GAME, flag fall, move button, pause.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      t1_d    = t1_q;
      t2_d    = t2_q;
      t_new_s = t_act_s;
      if (NEW_GAME) begin
         state_d = S_IDLE;
         last_d  = 1'b0;
         t1_d    = T_START;
         t2_d    = T_START;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (START) begin
                  state_d = S_RUN_P1;
                  last_d  = 1'b0;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_RUN_P1, S_RUN_P2: begin
               if (flag_hit_s) begin
                  t_new_s = 16'h0000;
                  state_d = S_FLAG;
               end else if (btn_act_s) begin
                  t_new_s = t_inc_s;
                  state_d = (state_q == S_RUN_P1) ? S_RUN_P2 : S_RUN_P1;
                  last_d  = (state_q == S_RUN_P1);
               end else if (PAUSE) begin
                  t_new_s = t_dec_s;
                  state_d = S_PAUSED;
               end else begin
                  t_new_s = t_dec_s;
               end
               if (state_q == S_RUN_P1) begin
                  t1_d = t_new_s;
               end else begin
                  t2_d = t_new_s;
               end
            end
            S_PAUSED: begin
               if (PAUSE || START) begin
                  state_d = last_q ? S_RUN_P2 : S_RUN_P1;
               end else begin
                  state_d = S_PAUSED;
               end
            end
            S_FLAG:  state_d = S_FLAG;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State, time registers and registered outputs.
   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         state_q <= S_IDLE;
         last_q  <= 1'b0;
         t1_q    <= T_START;
         t2_q    <= T_START;
         run_p1  <= 1'b0;
         run_p2  <= 1'b0;
         paused  <= 1'b0;
         flag_p1 <= 1'b0;
         flag_p2 <= 1'b0;
         seg1    <= 7'h00;
         seg2    <= 7'h00;
         seg3    <= 7'h00;
         seg4    <= 7'h00;
         seg5    <= 7'h00;
         seg6    <= 7'h00;
         seg7    <= 7'h00;
         seg8    <= 7'h00;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         t1_q    <= t1_d;
         t2_q    <= t2_d;
         run_p1  <= (state_d == S_RUN_P1);
         run_p2  <= (state_d == S_RUN_P2);
         paused  <= (state_d == S_PAUSED);
         flag_p1 <= (state_d == S_FLAG) & ~last_d;
         flag_p2 <= (state_d == S_FLAG) & last_d;
         // segments follow the time registers one cycle later
         seg1    <= seg_enc(t1_q[15:12]);
         seg2    <= seg_enc(t1_q[11:8]);
         seg3    <= seg_enc(t1_q[7:4]);
         seg4    <= seg_enc(t1_q[3:0]);
         seg5    <= seg_enc(t2_q[15:12]);
         seg6    <= seg_enc(t2_q[11:8]);
         seg7    <= seg_enc(t2_q[7:4]);
         seg8    <= seg_enc(t2_q[3:0]);
      end
   end

endmodule

// File: tb/tb_chess_time_core.sv
// -----------------------------------------------------------------------------
// tb_chess_time_core
// Directed, table-driven bench for chess_time_core. Two instances share the
// stimulus: A (START_MIN=5, INC_SEC=10) and B (START_MIN=1, INC_SEC=30).
// Expected times are written as BCD mm:ss and turned into segment patterns
// through the digit table; status is {run_p1, run_p2, paused, flag_p1, flag_p2}.
// -----------------------------------------------------------------------------
module tb_chess_time_core;

   logic CLK = 1'b0;
   logic CLR_N, CE, START, PAUSE, NEW_GAME, BTN_P1, BTN_P2;

   logic [6:0] sa [8];
   logic [6:0] sb [8];
   logic [4:0] fa, fb;

   int checks = 0;
   int errors = 0;

   logic [6:0] seg_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   typedef struct {
      logic [5:0]  in;   // {START, PAUSE, NEW_GAME, BTN_P1, BTN_P2, CE}
      logic [15:0] p1;
      logic [15:0] p2;
      logic [4:0]  st;   // {run_p1, run_p2, paused, flag_p1, flag_p2}
   } vec_t;

   vec_t tbl [26];

   always #5 CLK = ~CLK;

   chess_time_core #(.START_MIN(5), .INC_SEC(10)) dut_a (
      .CLK(CLK), .CLR_N(CLR_N), .CE(CE), .START(START), .PAUSE(PAUSE),
      .NEW_GAME(NEW_GAME), .BTN_P1(BTN_P1), .BTN_P2(BTN_P2),
      .seg1(sa[0]), .seg2(sa[1]), .seg3(sa[2]), .seg4(sa[3]),
      .seg5(sa[4]), .seg6(sa[5]), .seg7(sa[6]), .seg8(sa[7]),
      .run_p1(fa[4]), .run_p2(fa[3]), .paused(fa[2]),
      .flag_p1(fa[1]), .flag_p2(fa[0])
   );

   chess_time_core #(.START_MIN(1), .INC_SEC(30)) dut_b (
      .CLK(CLK), .CLR_N(CLR_N), .CE(CE), .START(START), .PAUSE(PAUSE),
      .NEW_GAME(NEW_GAME), .BTN_P1(BTN_P1), .BTN_P2(BTN_P2),
      .seg1(sb[0]), .seg2(sb[1]), .seg3(sb[2]), .seg4(sb[3]),
      .seg5(sb[4]), .seg6(sb[5]), .seg7(sb[6]), .seg8(sb[7]),
      .run_p1(fb[4]), .run_p2(fb[3]), .paused(fb[2]),
      .flag_p1(fb[1]), .flag_p2(fb[0])
   );

   function automatic logic [27:0] segs_of(input logic [15:0] t);
      return {seg_tbl[t[15:12]], seg_tbl[t[11:8]], seg_tbl[t[7:4]], seg_tbl[t[3:0]]};
   endfunction

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic check_dut(input int d, input string nm, input logic [15:0] e1,
                            input logic [15:0] e2, input logic [4:0] est);
      logic [27:0] a1, a2;
      logic [4:0]  ast;
      if (d == 0) begin
         a1  = {sa[0], sa[1], sa[2], sa[3]};
         a2  = {sa[4], sa[5], sa[6], sa[7]};
         ast = fa;
      end else begin
         a1  = {sb[0], sb[1], sb[2], sb[3]};
         a2  = {sb[4], sb[5], sb[6], sb[7]};
         ast = fb;
      end
      cmp({nm, " p1 segs"}, {4'h0, a1}, {4'h0, segs_of(e1)});
      cmp({nm, " p2 segs"}, {4'h0, a2}, {4'h0, segs_of(e2)});
      cmp({nm, " status"}, {27'h0, ast}, {27'h0, est});
   endtask

   task automatic check_cleared(input string nm);
      cmp({nm, " A p1 segs"}, {4'h0, sa[0], sa[1], sa[2], sa[3]}, 32'h0);
      cmp({nm, " A p2 segs"}, {4'h0, sa[4], sa[5], sa[6], sa[7]}, 32'h0);
      cmp({nm, " B p1 segs"}, {4'h0, sb[0], sb[1], sb[2], sb[3]}, 32'h0);
      cmp({nm, " B p2 segs"}, {4'h0, sb[4], sb[5], sb[6], sb[7]}, 32'h0);
      cmp({nm, " status"}, {22'h0, fa, fb}, 32'h0);
   endtask

   // one-cycle pulse of the given inputs
   task automatic pulse(input logic [5:0] in);
      @(negedge CLK);
      {START, PAUSE, NEW_GAME, BTN_P1, BTN_P2, CE} = in;
      @(negedge CLK);
      {START, PAUSE, NEW_GAME, BTN_P1, BTN_P2, CE} = 6'b000000;
   endtask

   // pulse plus one idle cycle so the segments have caught up
   task automatic drive(input logic [5:0] in);
      pulse(in);
      @(negedge CLK);
   endtask

   task automatic do_reset;
      @(negedge CLK);
      CLR_N = 1'b0;
      @(negedge CLK);
      CLR_N = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
   endtask

   initial begin
      CLR_N = 1'b0;
      {START, PAUSE, NEW_GAME, BTN_P1, BTN_P2, CE} = 6'b000000;

      //            in         P1        P2        status
      tbl[0]  = '{6'b100000, 16'h0500, 16'h0500, 5'b10000}; // START
      tbl[1]  = '{6'b000001, 16'h0459, 16'h0500, 5'b10000}; // minute borrow
      tbl[2]  = '{6'b000001, 16'h0458, 16'h0500, 5'b10000};
      tbl[3]  = '{6'b000001, 16'h0457, 16'h0500, 5'b10000};
      tbl[4]  = '{6'b000001, 16'h0456, 16'h0500, 5'b10000};
      tbl[5]  = '{6'b000001, 16'h0455, 16'h0500, 5'b10000};
      tbl[6]  = '{6'b000101, 16'h0504, 16'h0500, 5'b01000}; // CE+BTN_P1, +10 s
      tbl[7]  = '{6'b000001, 16'h0504, 16'h0459, 5'b01000};
      tbl[8]  = '{6'b000100, 16'h0504, 16'h0459, 5'b01000}; // wrong button
      tbl[9]  = '{6'b000010, 16'h0504, 16'h0509, 5'b10000}; // BTN_P2, +10 s
      tbl[10] = '{6'b000010, 16'h0504, 16'h0509, 5'b10000}; // wrong button
      tbl[11] = '{6'b000110, 16'h0504, 16'h0509, 5'b10000}; // both buttons
      tbl[12] = '{6'b010000, 16'h0504, 16'h0509, 5'b00100}; // PAUSE
      tbl[13] = '{6'b000001, 16'h0504, 16'h0509, 5'b00100}; // frozen
      tbl[14] = '{6'b000001, 16'h0504, 16'h0509, 5'b00100};
      tbl[15] = '{6'b000100, 16'h0504, 16'h0509, 5'b00100}; // button in pause
      tbl[16] = '{6'b010000, 16'h0504, 16'h0509, 5'b10000}; // resume P1
      tbl[17] = '{6'b010100, 16'h0514, 16'h0509, 5'b01000}; // PAUSE+BTN: button wins
      tbl[18] = '{6'b010001, 16'h0514, 16'h0508, 5'b00100}; // CE+PAUSE
      tbl[19] = '{6'b100000, 16'h0514, 16'h0508, 5'b01000}; // START resumes P2
      tbl[20] = '{6'b100000, 16'h0514, 16'h0508, 5'b01000}; // START ignored
      tbl[21] = '{6'b000011, 16'h0514, 16'h0517, 5'b10000}; // CE+BTN_P2
      tbl[22] = '{6'b001101, 16'h0500, 16'h0500, 5'b00000}; // NEW_GAME wins
      tbl[23] = '{6'b010000, 16'h0500, 16'h0500, 5'b00000}; // PAUSE in IDLE
      tbl[24] = '{6'b000101, 16'h0500, 16'h0500, 5'b00000}; // CE+BTN in IDLE
      tbl[25] = '{6'b100000, 16'h0500, 16'h0500, 5'b10000};

      // outputs blank while reset is held
      #12;
      check_cleared("in reset");
      @(negedge CLK);
      CLR_N = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
      check_dut(0, "reset A", 16'h0500, 16'h0500, 5'b00000);
      check_dut(1, "reset B", 16'h0100, 16'h0100, 5'b00000);

      for (int i = 0; i < 26; i++) begin
         drive(tbl[i].in);
         check_dut(0, $sformatf("vec%0d", i), tbl[i].p1, tbl[i].p2, tbl[i].st);
      end

      // flag fall on instance B: 60 ticks from 01:00, last one with BTN_P1
      do_reset;
      drive(6'b100000);
      check_dut(1, "flag start", 16'h0100, 16'h0100, 5'b10000);
      for (int i = 0; i < 59; i++) pulse(6'b000001);
      @(negedge CLK);
      check_dut(1, "tick59", 16'h0001, 16'h0100, 5'b10000);
      drive(6'b000101);
      check_dut(1, "tick60 flag", 16'h0000, 16'h0100, 5'b00010);
      begin
         logic [5:0] ign [5];
         ign = '{6'b000001, 6'b000100, 6'b000010, 6'b100000, 6'b010000};
         for (int i = 0; i < 5; i++) begin
            drive(ign[i]);
            check_dut(1, $sformatf("flag ignore%0d", i), 16'h0000, 16'h0100, 5'b00010);
         end
      end
      drive(6'b001000);
      check_dut(1, "new game", 16'h0100, 16'h0100, 5'b00000);

      // saturation on instance B: pump both players with +30 s moves
      drive(6'b100000);
      for (int i = 0; i < 200; i++) begin
         pulse(6'b000100);
         pulse(6'b000010);
      end
      @(negedge CLK);
      check_dut(1, "saturated", 16'h9959, 16'h9959, 5'b10000);
      pulse(6'b000100);
      for (int i = 0; i < 4; i++) pulse(6'b000001);
      @(negedge CLK);
      check_dut(1, "p2 99:55", 16'h9959, 16'h9955, 5'b01000);
      drive(6'b000010);
      check_dut(1, "p2 sat inc", 16'h9959, 16'h9959, 5'b10000);

      // asynchronous reset between clock edges
      @(negedge CLK);
      #2;
      CLR_N = 1'b0;
      #1;
      check_cleared("async reset");
      @(negedge CLK);
      CLR_N = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
